// File: rtl/buf_alloc_if.sv
// Handshake bundle between buf_alloc_ctrl, its client, the LFU block and the
// fill data path. The controller attaches through the slave modport; the
// environment (client, LFU, data path) drives the master side.
interface buf_alloc_if #(
  parameter int TAG_W = 8
);
  logic             req_vld;
  logic [TAG_W-1:0] req_tag;
  logic             req_rdy;
  logic             rsp_vld;
  logic             rsp_hit;
  logic [1:0]       rsp_buf;
  logic             new_buf_req;
  logic [1:0]       ref_buf_numbr;
  logic             ref_buf_vld;
  logic [1:0]       buf_num_replc;
  logic             fill_req;
  logic [1:0]       fill_buf;
  logic [TAG_W-1:0] fill_tag;
  logic             fill_done;

  modport master (
    output req_vld, req_tag, buf_num_replc, fill_done,
    input  req_rdy, rsp_vld, rsp_hit, rsp_buf, new_buf_req,
           ref_buf_numbr, ref_buf_vld, fill_req, fill_buf, fill_tag
  );

  modport slave (
    input  req_vld, req_tag, buf_num_replc, fill_done,
    output req_rdy, rsp_vld, rsp_hit, rsp_buf, new_buf_req,
           ref_buf_numbr, ref_buf_vld, fill_req, fill_buf, fill_tag
  );
endinterface

// File: rtl/buf_alloc_ctrl.sv
// Requester side of a 4-entry LFU-replaced buffer pool. Holds the tag/valid
// table, answers lookups, allocates on a miss (free entry first, otherwise the
// LFU victim) and runs a fill handshake before responding.
// Optional hit/miss statistics counters are compiled in with
// BUF_ALLOC_STATS_EN; without it those ports and counters do not exist.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | ready for a client request
// LOOKUP    | compare latched tag against the table
// VICT_REQ  | new_buf_req pulse to the LFU block is on the wire
// VICT_WAIT | LFU victim number is valid this cycle, capture it
// FILL      | fill_req held until the data path reports fill_done
// RESP      | miss response pulse is on the wire
module buf_alloc_ctrl #(
  parameter int TAG_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  buf_alloc_if.slave bus
`ifdef BUF_ALLOC_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    VICT_REQ  = 3'd2,
    VICT_WAIT = 3'd3,
    FILL      = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [3:0]       valid_q;
  logic [TAG_W-1:0] tags_q [4];

  logic             req_rdy_q, req_rdy_d;
  logic             rsp_vld_q, rsp_vld_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic [1:0]       rsp_buf_q, rsp_buf_d;
  logic             new_buf_req_q, new_buf_req_d;
  logic [1:0]       ref_buf_numbr_q, ref_buf_numbr_d;
  logic             ref_buf_vld_q, ref_buf_vld_d;
  logic             fill_req_q, fill_req_d;
  logic [1:0]       fill_buf_q, fill_buf_d;
  logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
  logic             fill_wr;

  logic             hit;
  logic [1:0]       hit_idx;
  logic             inv;
  logic [1:0]       inv_idx;

  assign bus.req_rdy       = req_rdy_q;
  assign bus.rsp_vld       = rsp_vld_q;
  assign bus.rsp_hit       = rsp_hit_q;
  assign bus.rsp_buf       = rsp_buf_q;
  assign bus.new_buf_req   = new_buf_req_q;
  assign bus.ref_buf_numbr = ref_buf_numbr_q;
  assign bus.ref_buf_vld   = ref_buf_vld_q;
  assign bus.fill_req      = fill_req_q;
  assign bus.fill_buf      = fill_buf_q;
  assign bus.fill_tag      = fill_tag_q;

  // Table match and lowest free entry; descending scan so the lowest index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    inv     = 1'b0;
    inv_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (valid_q[i] && (tags_q[i] == tag_q)) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
      if (!valid_q[i]) begin
        inv     = 1'b1;
        inv_idx = 2'(i);
      end
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_d         = state_q;
    tag_d           = tag_q;
    req_rdy_d       = req_rdy_q;
    rsp_vld_d       = 1'b0;
    rsp_hit_d       = rsp_hit_q;
    rsp_buf_d       = rsp_buf_q;
    new_buf_req_d   = 1'b0;
    ref_buf_numbr_d = ref_buf_numbr_q;
    ref_buf_vld_d   = 1'b0;
    fill_req_d      = fill_req_q;
    fill_buf_d      = fill_buf_q;
    fill_tag_d      = fill_tag_q;
    fill_wr         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_vld) begin
          tag_d     = bus.req_tag;
          req_rdy_d = 1'b0;
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          rsp_vld_d       = 1'b1;
          rsp_hit_d       = 1'b1;
          rsp_buf_d       = hit_idx;
          ref_buf_vld_d   = 1'b1;
          ref_buf_numbr_d = hit_idx;
          req_rdy_d       = 1'b1;
          state_d         = IDLE;
        end else if (inv) begin
          fill_req_d = 1'b1;
          fill_buf_d = inv_idx;
          fill_tag_d = tag_q;
          state_d    = FILL;
        end else begin
          new_buf_req_d = 1'b1;
          state_d       = VICT_REQ;
        end
      end
      VICT_REQ: begin
        state_d = VICT_WAIT;
      end
      VICT_WAIT: begin
        fill_req_d = 1'b1;
        fill_buf_d = bus.buf_num_replc;
        fill_tag_d = tag_q;
        state_d    = FILL;
      end
      FILL: begin
        if (bus.fill_done) begin
          fill_wr         = 1'b1;
          fill_req_d      = 1'b0;
          rsp_vld_d       = 1'b1;
          rsp_hit_d       = 1'b0;
          rsp_buf_d       = fill_buf_q;
          ref_buf_vld_d   = 1'b1;
          ref_buf_numbr_d = fill_buf_q;
          state_d         = RESP;
        end
      end
      RESP: begin
        req_rdy_d = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        req_rdy_d  = 1'b1;
        fill_req_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // FSM state, latched request tag and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      tag_q           <= '0;
      req_rdy_q       <= 1'b1;
      rsp_vld_q       <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_buf_q       <= 2'd0;
      new_buf_req_q   <= 1'b0;
      ref_buf_numbr_q <= 2'd0;
      ref_buf_vld_q   <= 1'b0;
      fill_req_q      <= 1'b0;
      fill_buf_q      <= 2'd0;
      fill_tag_q      <= '0;
    end else begin
      state_q         <= state_d;
      tag_q           <= tag_d;
      req_rdy_q       <= req_rdy_d;
      rsp_vld_q       <= rsp_vld_d;
      rsp_hit_q       <= rsp_hit_d;
      rsp_buf_q       <= rsp_buf_d;
      new_buf_req_q   <= new_buf_req_d;
      ref_buf_numbr_q <= ref_buf_numbr_d;
      ref_buf_vld_q   <= ref_buf_vld_d;
      fill_req_q      <= fill_req_d;
      fill_buf_q      <= fill_buf_d;
      fill_tag_q      <= fill_tag_d;
    end
  end

  // Tag table: an entry becomes valid only when its fill completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 4'd0;
      for (int i = 0; i < 4; i++) tags_q[i] <= '0;
    end else if (fill_wr) begin
      valid_q[fill_buf_q] <= 1'b1;
      tags_q[fill_buf_q]  <= fill_tag_q;
    end
  end

`ifdef BUF_ALLOC_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // Saturating response counters, stepped by each registered response pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else if (rsp_vld_q) begin
      if (rsp_hit_q) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_buf_alloc_ctrl.sv
// Directed bench for buf_alloc_ctrl: cold misses, hits, LFU victim path with a
// stalled fill, reset during a fill, and (with BUF_ALLOC_STATS_EN) counters.
module tb_buf_alloc_ctrl;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;
  int   nbr_cnt;
  int   overlap_cnt;

  buf_alloc_if #(.TAG_W(8)) bus ();

`ifdef BUF_ALLOC_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  buf_alloc_ctrl #(.TAG_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BUF_ALLOC_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LFU-side monitor: victim requests and illegal overlap with ref_buf_vld.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.new_buf_req) nbr_cnt++;
      if (bus.new_buf_req && bus.ref_buf_vld) overlap_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_rdy"},       32'(bus.req_rdy),       1);
    check({pfx, "_rsp_vld"},       32'(bus.rsp_vld),       0);
    check({pfx, "_rsp_hit"},       32'(bus.rsp_hit),       0);
    check({pfx, "_rsp_buf"},       32'(bus.rsp_buf),       0);
    check({pfx, "_new_buf_req"},   32'(bus.new_buf_req),   0);
    check({pfx, "_ref_buf_numbr"}, 32'(bus.ref_buf_numbr), 0);
    check({pfx, "_ref_buf_vld"},   32'(bus.ref_buf_vld),   0);
    check({pfx, "_fill_req"},      32'(bus.fill_req),      0);
    check({pfx, "_fill_buf"},      32'(bus.fill_buf),      0);
    check({pfx, "_fill_tag"},      32'(bus.fill_tag),      0);
  endtask

  task automatic hit_req(input logic [7:0] tag, input logic [1:0] exp_buf);
    @(negedge clk);
    check("hit_rdy_idle", 32'(bus.req_rdy), 1);
    bus.req_vld = 1'b1;
    bus.req_tag = tag;
    @(negedge clk);
    bus.req_vld = 1'b0;
    check("hit_rdy_busy", 32'(bus.req_rdy), 0);
    check("hit_early_rsp", 32'(bus.rsp_vld), 0);
    @(negedge clk);
    check("hit_rsp_vld", 32'(bus.rsp_vld), 1);
    check("hit_rsp_hit", 32'(bus.rsp_hit), 1);
    check("hit_rsp_buf", 32'(bus.rsp_buf), 32'(exp_buf));
    check("hit_ref_vld", 32'(bus.ref_buf_vld), 1);
    check("hit_ref_num", 32'(bus.ref_buf_numbr), 32'(exp_buf));
    check("hit_fill_req", 32'(bus.fill_req), 0);
  endtask

  task automatic miss_req(input logic [7:0] tag, input logic [1:0] exp_buf,
                          input int exp_wait, input int stall);
    int n;
    @(negedge clk);
    check("miss_rdy_idle", 32'(bus.req_rdy), 1);
    bus.req_vld = 1'b1;
    bus.req_tag = tag;
    @(negedge clk);
    bus.req_vld = 1'b0;
    check("miss_rdy_busy", 32'(bus.req_rdy), 0);
    n = 0;
    while (!bus.fill_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("miss_fill_wait", 32'(n), 32'(exp_wait));
    check("miss_fill_req", 32'(bus.fill_req), 1);
    check("miss_fill_buf", 32'(bus.fill_buf), 32'(exp_buf));
    check("miss_fill_tag", 32'(bus.fill_tag), 32'(tag));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_fill_req", 32'(bus.fill_req), 1);
      check("stall_fill_buf", 32'(bus.fill_buf), 32'(exp_buf));
      check("stall_fill_tag", 32'(bus.fill_tag), 32'(tag));
      check("stall_req_rdy", 32'(bus.req_rdy), 0);
      check("stall_rsp_vld", 32'(bus.rsp_vld), 0);
    end
    bus.fill_done = 1'b1;
    @(negedge clk);
    bus.fill_done = 1'b0;
    check("miss_rsp_vld", 32'(bus.rsp_vld), 1);
    check("miss_rsp_hit", 32'(bus.rsp_hit), 0);
    check("miss_rsp_buf", 32'(bus.rsp_buf), 32'(exp_buf));
    check("miss_ref_vld", 32'(bus.ref_buf_vld), 1);
    check("miss_ref_num", 32'(bus.ref_buf_numbr), 32'(exp_buf));
    check("miss_fill_clr", 32'(bus.fill_req), 0);
  endtask

  initial begin
    int n;
    vectors         = 0;
    errors          = 0;
    nbr_cnt         = 0;
    overlap_cnt     = 0;
    rst             = 1'b1;
    bus.req_vld     = 1'b0;
    bus.req_tag     = 8'h00;
    bus.buf_num_replc = 2'd0;
    bus.fill_done   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    check("rst_valid", 32'(dut.valid_q), 0);
    rst = 1'b0;

    // Cold misses fill entries 0..3 without involving the LFU
    miss_req(8'h10, 2'd0, 1, 0);
    miss_req(8'h11, 2'd1, 1, 0);
    miss_req(8'h12, 2'd2, 1, 0);
    miss_req(8'h13, 2'd3, 1, 0);
    check("cold_no_victim_req", 32'(nbr_cnt), 0);

    // Hits
    hit_req(8'h12, 2'd2);
    hit_req(8'h10, 2'd0);

    // Table full: LFU picks entry 1, fill stalls for 10 cycles
    bus.buf_num_replc = 2'd1;
    miss_req(8'h20, 2'd1, 3, 10);
    check("lfu_one_pulse", 32'(nbr_cnt), 1);
    hit_req(8'h20, 2'd1);

    // 0x11 was evicted; now it misses and LFU picks entry 3
    bus.buf_num_replc = 2'd3;
    miss_req(8'h11, 2'd3, 3, 0);
    check("lfu_two_pulses", 32'(nbr_cnt), 2);
    hit_req(8'h12, 2'd2);

    // fill_done while idle is ignored
    @(negedge clk);
    bus.fill_done = 1'b1;
    repeat (2) @(negedge clk);
    check("stray_done_fill_req", 32'(bus.fill_req), 0);
    check("stray_done_rsp_vld", 32'(bus.rsp_vld), 0);
    check("stray_done_rdy", 32'(bus.req_rdy), 1);
    bus.fill_done = 1'b0;

    // Reset while a fill is pending
    bus.buf_num_replc = 2'd2;
    @(negedge clk);
    bus.req_vld = 1'b1;
    bus.req_tag = 8'h40;
    @(negedge clk);
    bus.req_vld = 1'b0;
    n = 0;
    while (!bus.fill_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("midfill_fill_req", 32'(bus.fill_req), 1);
    check("midfill_fill_buf", 32'(bus.fill_buf), 2);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    check("midrst_valid", 32'(dut.valid_q), 0);
    @(negedge clk);
    rst = 1'b0;

    // After reset the table is empty again
    miss_req(8'h20, 2'd0, 1, 0);
    check("victim_ref_overlap", 32'(overlap_cnt), 0);

`ifdef BUF_ALLOC_STATS_EN
    // Counters restarted at the mid-fill reset: 1 miss so far
    hit_req(8'h20, 2'd0);
    hit_req(8'h20, 2'd0);
    hit_req(8'h20, 2'd0);
    miss_req(8'h50, 2'd1, 1, 0);
    miss_req(8'h51, 2'd2, 1, 0);
    miss_req(8'h52, 2'd3, 1, 0);
    bus.buf_num_replc = 2'd2;
    miss_req(8'h53, 2'd2, 3, 0);
    @(negedge clk);
    check("stats_hit_cnt", 32'(hit_cnt), 3);
    check("stats_miss_cnt", 32'(miss_cnt), 5);
    force dut.hit_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.hit_cnt_q;
    hit_req(8'h20, 2'd0);
    @(negedge clk);
    check("stats_hit_sat", 32'(hit_cnt), 32'h0000FFFF);
    check("stats_miss_hold", 32'(miss_cnt), 5);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
